// File: rtl/stream_pkg.sv
// Shared definitions for the 8-to-1 round-robin stream mux.
//   N_CH          number of input channels
//   SEL_W         width of a channel index
//   mux_state_t   IDLE: free to arbitrate; LOCK: a packet is in flight
//   sel_to_onehot index -> one-hot channel mask
package stream_pkg;

  localparam int N_CH  = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } mux_state_t;

  function automatic logic [N_CH-1:0] sel_to_onehot(input logic [SEL_W-1:0] s);
    logic [N_CH-1:0] r;
    r    = '0;
    r[s] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter_8.sv
// Combinational 8-way round-robin arbiter.
//   req      in   request per channel
//   ptr      in   highest-priority channel; search goes ptr, ptr+1, ... (mod 8)
//   gnt      out  one-hot grant (all zero when nothing requests)
//   gnt_idx  out  index of the granted channel (0 when nothing requests)
//   any      out  at least one request present
module rr_arbiter_8
  import stream_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N_CH-1:0]  gnt,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             any
);

  always_comb begin
    logic [SEL_W-1:0] idx;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = '0;
    // Walk the channels starting at ptr; the 3-bit add wraps 7 -> 0.
    for (int k = 0; k < N_CH; k++) begin
      idx = ptr + SEL_W'(k);
      if (!any && req[idx]) begin
        any          = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = idx;
      end
    end
  end

endmodule

// File: rtl/stream_mux_8x1_rr.sv
// Merges eight valid/ready packet streams onto one registered output using
// round-robin arbitration at packet granularity (packets never interleave).
// Each output beat carries the index of its source channel in out_sel.
//   clk, rst        clock, synchronous active-high reset
//   in_valid/in_data/in_last/in_ready   eight input streams (channel i at
//                   in_data[i*WIDTH +: WIDTH])
//   out_valid/out_data/out_last/out_sel/out_ready   merged output stream
//   dbg_state, dbg_ptr, dbg_lock_ch     internal arbitration state
//
// Handshake: a beat moves when valid and ready are both high at a rising
// clock edge. A producer holds valid and its payload until accepted; ready
// may depend combinationally on valid. The output register stays stable
// while out_valid=1 and out_ready=0.
module stream_mux_8x1_rr
  import stream_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_last,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_last,
  output logic [SEL_W-1:0]      out_sel,
  input  logic                  out_ready,
  output mux_state_t            dbg_state,
  output logic [SEL_W-1:0]      dbg_ptr,
  output logic [SEL_W-1:0]      dbg_lock_ch
);

  mux_state_t       state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] lock_q, lock_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;

  logic             load;
  logic             xfer;
  logic [N_CH-1:0]  arb_req;
  logic [N_CH-1:0]  gnt;
  logic [SEL_W-1:0] gnt_idx;
  logic             arb_any;
  logic [WIDTH-1:0] g_data;
  logic             g_last;

  // The output register can take a beat when it is empty or being drained.
  assign load = ~out_valid_q | out_ready;

  // While a packet is in flight only its channel may compete; bubbles on it
  // simply produce no grant rather than letting another channel in.
  assign arb_req = (state_q == ST_LOCK) ? (in_valid & sel_to_onehot(lock_q)) : in_valid;

  rr_arbiter_8 u_arb (
    .req     (arb_req),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (arb_any)
  );

  assign in_ready = (load && !rst) ? gnt : '0;
  assign xfer     = arb_any & load & ~rst;
  assign g_data   = in_data[int'(gnt_idx)*WIDTH +: WIDTH];
  assign g_last   = in_last[gnt_idx];

  // Packet-level FSM: the pointer only advances when a packet ends.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    lock_d  = lock_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          if (g_last) begin
            ptr_d = gnt_idx + SEL_W'(1);
          end else begin
            state_d = ST_LOCK;
            lock_d  = gnt_idx;
          end
        end
      end
      ST_LOCK: begin
        if (xfer && g_last) begin
          state_d = ST_IDLE;
          ptr_d   = lock_q + SEL_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output register: a new beat replaces the old one in the same cycle it
  // is consumed, so back-to-back beats flow without bubbles.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = g_data;
      out_last_d  = g_last;
      out_sel_d   = gnt_idx;
    end else if (load && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      lock_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      lock_q      <= lock_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_last    = out_last_q;
  assign out_sel     = out_sel_q;
  assign dbg_state   = state_q;
  assign dbg_ptr     = ptr_q;
  assign dbg_lock_ch = lock_q;

endmodule

// File: tb/tb_stream_mux_8x1_rr.sv
module tb_stream_mux_8x1_rr;
  import stream_pkg::*;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [7:0]       in_valid;
  logic [8*W-1:0]   in_data;
  logic [7:0]       in_last;
  logic [7:0]       in_ready;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic             out_last;
  logic [2:0]       out_sel;
  logic             out_ready;
  mux_state_t       dbg_state;
  logic [2:0]       dbg_ptr;
  logic [2:0]       dbg_lock_ch;

  stream_mux_8x1_rr #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_sel     (out_sel),
    .out_ready   (out_ready),
    .dbg_state   (dbg_state),
    .dbg_ptr     (dbg_ptr),
    .dbg_lock_ch (dbg_lock_ch)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- scoreboard / reference data ----------------
  logic [11:0] exp_q[$];          // {sel, last, data} in expected output order
  logic [8:0]  beat_mem[8][32];   // {last, data} per channel, in send order
  int          n_beats[8];
  int          rd[8];
  int          pos[8];

  // ---------------- driver / check tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int sel, input bit last, input logic [7:0] d);
    chk(tag, {19'b0, out_valid, out_sel, out_last, out_data},
             {19'b0, 1'b1, 3'(sel), last, d});
  endtask

  task automatic set_ch(input int c, input bit v, input logic [7:0] d, input bit l);
    in_valid[c]      = v;
    in_data[c*W +: W] = d;
    in_last[c]       = l;
  endtask

  initial begin
    int          mp;
    int          found;
    int          cyc;
    bit          done;
    logic [8:0]  e;
    logic [11:0] x;
    logic [7:0]  mid, pend, acc;

    // ---- reset with every channel requesting ----
    rst       = 1'b1;
    out_ready = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    in_last   = '0;
    for (int i = 0; i < 8; i++) set_ch(i, 1'b1, 8'(8'h10 + i), 1'b1);
    tick();
    chk("rst_rdy_c1", 32'(in_ready), 32'h0);
    chk("rst_oval_c1", 32'(out_valid), 32'h0);
    tick();
    chk("rst_rdy_c2", 32'(in_ready), 32'h0);
    chk("rst_out", {19'b0, out_valid, out_sel, out_last, out_data}, 32'h0);
    chk("rst_ptr", 32'(dbg_ptr), 32'h0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    settle();
    chk("first_grant_ch0", 32'(in_ready), 32'h01);

    // ---- fairness: single-beat packets on all channels ----
    for (int k = 0; k < 9; k++) begin
      tick();
      chk_out("fair_beat", k % 8, 1'b1, 8'(8'h10 + (k % 8)));
      chk("fair_rdy", 32'(in_ready), 32'(1) << ((k + 1) % 8));
    end
    in_valid = '0;
    tick();
    chk("fair_drain", 32'(out_valid), 32'h0);
    chk("fair_ptr", 32'(dbg_ptr), 32'd1);

    // ---- no interleave: ch2 4-beat packet, ch5 waiting ----
    for (int b = 0; b < 4; b++) begin
      in_valid = '0;
      set_ch(2, 1'b1, 8'(8'hA0 + b), b == 3);
      set_ch(5, 1'b1, 8'h55, 1'b1);
      settle();
      chk("pkt_rdy", 32'(in_ready), 32'h04);
      tick();
      chk_out("pkt_beat", 2, b == 3, 8'(8'hA0 + b));
      chk("pkt_state", 32'(dbg_state), (b < 3) ? 32'(ST_LOCK) : 32'(ST_IDLE));
    end
    in_valid[2] = 1'b0;
    settle();
    chk("pkt_next_rdy", 32'(in_ready), 32'h20);
    tick();
    chk_out("pkt_next_ch5", 5, 1'b1, 8'h55);
    in_valid = '0;
    tick();
    chk("pkt_drain", 32'(out_valid), 32'h0);
    chk("pkt_ptr", 32'(dbg_ptr), 32'd6);

    // ---- backpressure ----
    set_ch(0, 1'b1, 8'h30, 1'b1);
    set_ch(3, 1'b1, 8'h33, 1'b1);
    tick();
    chk_out("bp_first", 0, 1'b1, 8'h30);
    out_ready = 1'b0;
    settle();
    chk("bp_rdy_off", 32'(in_ready), 32'h0);
    for (int s = 0; s < 5; s++) begin
      tick();
      chk_out("bp_hold", 0, 1'b1, 8'h30);
      chk("bp_hold_rdy", 32'(in_ready), 32'h0);
    end
    out_ready = 1'b1;
    settle();
    chk("bp_release_rdy", 32'(in_ready), 32'h08);
    tick();
    chk_out("bp_after_1", 3, 1'b1, 8'h33);
    tick();
    chk_out("bp_after_2", 0, 1'b1, 8'h30);
    tick();
    chk_out("bp_after_3", 3, 1'b1, 8'h33);
    in_valid = '0;
    tick();
    chk("bp_drain", 32'(out_valid), 32'h0);

    // ---- wrap and skip: move ptr to 6, then only ch7 and ch1 ----
    set_ch(5, 1'b1, 8'h65, 1'b1);
    tick();
    chk_out("wrap_setup", 5, 1'b1, 8'h65);
    in_valid = '0;
    set_ch(7, 1'b1, 8'h77, 1'b1);
    set_ch(1, 1'b1, 8'h71, 1'b1);
    settle();
    chk("wrap_ptr", 32'(dbg_ptr), 32'd6);
    chk("wrap_rdy", 32'(in_ready), 32'h80);
    tick();
    chk_out("wrap_1", 7, 1'b1, 8'h77);
    tick();
    chk_out("wrap_2", 1, 1'b1, 8'h71);
    tick();
    chk_out("wrap_3", 7, 1'b1, 8'h77);
    in_valid = '0;
    tick();
    chk("wrap_drain", 32'(out_valid), 32'h0);

    // ---- reset in the middle of a ch3 packet ----
    set_ch(3, 1'b1, 8'hC0, 1'b0);
    tick();
    chk_out("mid_b1", 3, 1'b0, 8'hC0);
    chk("mid_lock", 32'(dbg_state), 32'(ST_LOCK));
    set_ch(3, 1'b1, 8'hC1, 1'b0);
    tick();
    chk_out("mid_b2", 3, 1'b0, 8'hC1);
    rst = 1'b1;
    settle();
    chk("mid_rst_rdy", 32'(in_ready), 32'h0);
    tick();
    chk("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("mid_rst_out", {19'b0, out_valid, out_sel, out_last, out_data}, 32'h0);
    chk("mid_rst_ptr", 32'(dbg_ptr), 32'd0);
    rst = 1'b0;
    set_ch(0, 1'b1, 8'h0A, 1'b1);
    set_ch(3, 1'b1, 8'hC2, 1'b1);
    settle();
    chk("mid_after_rdy", 32'(in_ready), 32'h01);
    tick();
    chk_out("mid_after_ch0", 0, 1'b1, 8'h0A);
    in_valid = '0;
    tick();

    // ---- randomized packets against a packet-level reference ----
    rst       = 1'b1;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      int npk;
      n_beats[c] = 0;
      rd[c]      = 0;
      pos[c]     = 0;
      npk        = $urandom_range(0, 3);
      for (int p = 0; p < npk; p++) begin
        int len;
        len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++) begin
          beat_mem[c][n_beats[c]] = {b == len - 1, 8'($urandom)};
          n_beats[c]++;
        end
      end
    end
    // Whole packets go out in turn; the next one comes from the first
    // channel with work at or after the one following the last sender.
    exp_q.delete();
    mp   = 0;
    done = 1'b0;
    while (!done) begin
      found = -1;
      for (int k = 0; k < 8; k++) begin
        int c;
        c = (mp + k) % 8;
        if (found < 0 && pos[c] < n_beats[c]) found = c;
      end
      if (found < 0) begin
        done = 1'b1;
      end else begin
        e = 9'h100;
        do begin
          e = beat_mem[found][pos[found]];
          exp_q.push_back({3'(found), e});
          pos[found]++;
        end while (!e[8]);
        mp = (found + 1) % 8;
      end
    end

    mid  = '0;
    pend = '0;
    cyc  = 0;
    while (exp_q.size() > 0 && cyc < 3000) begin
      for (int c = 0; c < 8; c++) begin
        bit v;
        if (rd[c] >= n_beats[c]) v = 1'b0;
        else if (mid[c] && !pend[c] && $urandom_range(0, 3) == 0) v = 1'b0;
        else v = 1'b1;
        set_ch(c, v, beat_mem[c][rd[c]][7:0], beat_mem[c][rd[c]][8]);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      settle();
      chk("rnd_rdy_onehot0", 32'($onehot0(in_ready)), 32'd1);
      acc = in_valid & in_ready;
      if (out_valid && out_ready && exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("rnd_beat", {19'b0, out_sel, out_last, out_data}, {20'b0, x});
      end
      pend = in_valid & ~acc;
      tick();
      for (int c = 0; c < 8; c++) begin
        if (acc[c]) begin
          mid[c] = ~beat_mem[c][rd[c]][8];
          rd[c]++;
        end
      end
      cyc++;
    end
    chk("rnd_all_delivered", 32'(exp_q.size()), 32'd0);
    in_valid = '0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
